step_sched: RTL



---
 rtl/pluto_step_pkg.sv | 19 +
 rtl/step_sched_if.sv | 32 +++
 rtl/stepgen_chan_next.sv | 53 +++++
 rtl/step_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/pluto_step_pkg.sv
// Shared constants, FSM encoding and bus-offset helpers for the step scheduler.
package pluto_step_pkg;

    localparam int DEF_N = 4;   // channels
    localparam int DEF_W = 10;  // integer position bits
    localparam int DEF_F = 11;  // fractional position bits
    localparam int DEF_T = 4;   // step/dir timer bits

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_e;

    // Low bit of channel k's field in a flattened bus of w-bit fields.
    function automatic int fld_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/step_sched_if.sv
// Register-file / pin side of the step scheduler. The register file drives
// through the master modport; the scheduler consumes through slave.
interface step_sched_if
    import pluto_step_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    parameter int F = DEF_F,
    parameter int T = DEF_T
) ();

    logic               tick;
    logic [N*(F+1)-1:0] vel;
    logic [T-1:0]       dirtime;
    logic [T-1:0]       steptime;
    logic [N*(W+F)-1:0] pos;
    logic [N-1:0]       step;
    logic [N-1:0]       dir;
    logic               busy;
    logic               overrun;

    modport master (
        output tick, vel, dirtime, steptime,
        input  pos, step, dir, busy, overrun
    );

    modport slave (
        input  tick, vel, dirtime, steptime,
        output pos, step, dir, busy, overrun
    );

endinterface

// File: rtl/stepgen_chan_next.sv
// Next-state logic for one step/dir channel; evaluated once per service slot.
module stepgen_chan_next
    import pluto_step_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int F = DEF_F,
    parameter int T = DEF_T
) (
    input  logic [W+F-1:0] pos_i,
    input  logic           step_i,
    input  logic           dir_i,
    input  logic [T-1:0]   timer_i,
    input  logic [F:0]     vel_i,
    input  logic [T-1:0]   dirtime_i,
    input  logic [T-1:0]   steptime_i,
    output logic [W+F-1:0] pos_o,
    output logic           step_o,
    output logic           dir_o,
    output logic [T-1:0]   timer_o
);

    localparam logic [T-1:0] ONE_T = 1;

    logic [W+F-1:0] pos_sum;

    // Velocity is sign-extended to the full position width; overflow wraps.
    assign pos_sum = pos_i + {{(W-1){vel_i[F]}}, vel_i};

    // Priority: pending timer, end of step pulse, direction change, accumulate.
    always_comb begin
        pos_o   = pos_i;
        step_o  = step_i;
        dir_o   = dir_i;
        timer_o = timer_i;
        if (timer_i != '0) begin
            timer_o = timer_i - ONE_T;
        end else if (step_i) begin
            step_o  = 1'b0;
            timer_o = steptime_i;
        end else if (vel_i[F] != dir_i) begin
            dir_o   = vel_i[F];
            timer_o = dirtime_i;
        end else begin
            pos_o = pos_sum;
            // |vel| <= 2^F, so bit F can flip at most once per service.
            if (pos_sum[F] != pos_i[F]) begin
                step_o  = 1'b1;
                timer_o = steptime_i;
            end
        end
    end

endmodule

// File: rtl/step_sched.sv
// Time-multiplexed step/dir generator: one shared channel datapath swept
// round-robin over N channels on each tick.
module step_sched
    import pluto_step_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    parameter int F = DEF_F,
    parameter int T = DEF_T
) (
    input  logic         clk,
    input  logic         reset,
    step_sched_if.slave  bus
);

    localparam int PW = W + F;
    localparam int VW = F + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N - 1);
    localparam logic [CW-1:0] ONE_CH  = 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic           overrun_q, overrun_d;

    logic [PW-1:0]  pos_q   [N];
    logic           step_q  [N];
    logic           dir_q   [N];
    logic [T-1:0]   timer_q [N];

    logic [VW-1:0]  vel_sel;
    logic [PW-1:0]  pos_nx;
    logic           step_nx;
    logic           dir_nx;
    logic [T-1:0]   timer_nx;

    // Sweep sequencer and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state: start a sweep on tick, walk channels, flag ticks lost mid-sweep.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.tick) begin
                    state_d = ST_SERVICE;
                    ch_d    = '0;
                end
            end
            ST_SERVICE: begin
                if (bus.tick) overrun_d = 1'b1;
                if (ch_q == LAST_CH) begin
                    state_d = ST_IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + ONE_CH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
            end
        endcase
    end

    assign vel_sel = bus.vel[fld_lo(int'(ch_q), VW) +: VW];

    stepgen_chan_next #(.W(W), .F(F), .T(T)) u_next (
        .pos_i      (pos_q[ch_q]),
        .step_i     (step_q[ch_q]),
        .dir_i      (dir_q[ch_q]),
        .timer_i    (timer_q[ch_q]),
        .vel_i      (vel_sel),
        .dirtime_i  (bus.dirtime),
        .steptime_i (bus.steptime),
        .pos_o      (pos_nx),
        .step_o     (step_nx),
        .dir_o      (dir_nx),
        .timer_o    (timer_nx)
    );

    // Write the served channel's results back; others hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                pos_q[k]   <= '0;
                step_q[k]  <= 1'b0;
                dir_q[k]   <= 1'b0;
                timer_q[k] <= '0;
            end
        end else if (state_q == ST_SERVICE) begin
            pos_q[ch_q]   <= pos_nx;
            step_q[ch_q]  <= step_nx;
            dir_q[ch_q]   <= dir_nx;
            timer_q[ch_q] <= timer_nx;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign bus.pos[k*PW +: PW] = pos_q[k];
        assign bus.step[k]         = step_q[k];
        assign bus.dir[k]          = dir_q[k];
    end

    assign bus.busy    = (state_q == ST_SERVICE);
    assign bus.overrun = overrun_q;

endmodule
